// File: rtl/decoder.sv
// Token-to-byte decoder: looks up each token id in a zero-terminated vocab table
// and streams the matching entry's bytes to consecutive output addresses.
module decoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic [ADDR_WIDTH-1:0] tok_len,
    output logic [ADDR_WIDTH-1:0] ar,
    input  logic [DATA_WIDTH-1:0] tok_data,
    output logic [ADDR_WIDTH-1:0] av,
    input  logic [DATA_WIDTH-1:0] val_vocab,
    output logic [ADDR_WIDTH-1:0] ao,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w,
    output logic                  done,
    output logic                  err,
    output logic [3:0]            dbg_state_o
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        TOK_RD   = 4'd1,
        TOK_WAIT = 4'd2,
        SEEK_RD  = 4'd3,
        SEEK_CHK = 4'd4,
        COPY_RD  = 4'd5,
        COPY_CHK = 4'd6,
        DONE     = 4'd7,
        ERR      = 4'd8
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH-1:0] ti_q, ti_d;
    logic [DATA_WIDTH-1:0] npv_q, npv_d;
    logic [ADDR_WIDTH-1:0] av_q, av_d;
    // Extra MSB records that the output pointer has run past the last address.
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;

    logic                  byte_is_term;
    logic                  av_last;
    logic                  wr_ovf;
    logic [DATA_WIDTH-1:0] npv_left;
    logic                  write_en;

    assign byte_is_term = (val_vocab == '0);
    assign av_last      = (av_q == {ADDR_WIDTH{1'b1}});
    assign wr_ovf       = wptr_q[ADDR_WIDTH];
    assign npv_left     = byte_is_term ? (npv_q - DATA_WIDTH'(1)) : npv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            ti_q    <= '0;
            npv_q   <= '0;
            av_q    <= '0;
            wptr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ti_q    <= ti_d;
            npv_q   <= npv_d;
            av_q    <= av_d;
            wptr_q  <= wptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ti_d    = ti_q;
        npv_d   = npv_q;
        av_d    = av_q;
        wptr_d  = wptr_q;
        unique case (state_q)
            IDLE: begin
                if (cs) begin
                    len_d   = tok_len;
                    ti_d    = '0;
                    wptr_d  = '0;
                    state_d = (tok_len == '0) ? DONE : TOK_RD;
                end
            end
            TOK_RD: state_d = TOK_WAIT;
            TOK_WAIT: begin
                // npv counts terminators still to skip before the wanted entry.
                npv_d   = tok_data;
                av_d    = '0;
                state_d = (tok_data == '0) ? COPY_RD : SEEK_RD;
            end
            SEEK_RD: state_d = SEEK_CHK;
            SEEK_CHK: begin
                npv_d = npv_left;
                av_d  = av_q + ADDR_WIDTH'(1);
                if (npv_left == '0) begin
                    state_d = COPY_RD;
                end else if (av_last) begin
                    state_d = ERR;
                end else begin
                    state_d = SEEK_RD;
                end
            end
            COPY_RD: state_d = COPY_CHK;
            COPY_CHK: begin
                if (byte_is_term) begin
                    ti_d    = ti_q + ADDR_WIDTH'(1);
                    state_d = (ti_q == len_q - ADDR_WIDTH'(1)) ? DONE : TOK_RD;
                end else if (av_last || wr_ovf) begin
                    state_d = ERR;
                end else begin
                    wptr_d  = wptr_q + (ADDR_WIDTH+1)'(1);
                    av_d    = av_q + ADDR_WIDTH'(1);
                    state_d = COPY_RD;
                end
            end
            DONE: if (!cs) state_d = IDLE;
            ERR:  if (!cs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        write_en    = (state_q == COPY_CHK) && !byte_is_term && !av_last && !wr_ovf;
        w           = write_en;
        w_data      = write_en ? val_vocab : '0;
        ao          = write_en ? wptr_q[ADDR_WIDTH-1:0] : '0;
        ar          = (state_q == TOK_RD) ? ti_q : '0;
        av          = av_q;
        done        = (state_q == DONE);
        err         = (state_q == ERR);
        dbg_state_o = state_q;
    end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameters: ADDR_WIDTH, default 4, width of all memory addresses and of tok_len; DATA_WIDTH, default 8, width of token ids and vocab/output bytes.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cs  input  1  chip select; high in IDLE starts a decode run.
REQ-005 tok_len  input  ADDR_WIDTH  number of token ids to decode; sampled on start.
REQ-006 ar  output  ADDR_WIDTH  token memory read address.
REQ-007 tok_data  input  DATA_WIDTH  token id; valid the cycle after ar is presented.
REQ-008 av  output  ADDR_WIDTH  vocab memory read address.
REQ-009 val_vocab  input  DATA_WIDTH  vocab byte; valid the cycle after av is presented.
REQ-010 ao  output  ADDR_WIDTH  output memory write address.
REQ-011 w_data  output  DATA_WIDTH  output write data.
REQ-012 w  output  1  output write strobe; one byte written per cycle w=1.
REQ-013 done  output  1  run finished normally.
REQ-014 err  output  1  run aborted.

Function
REQ-015 Vocab format: entries stored back-to-back from vocab address 0, each terminated by byte 0x00; token id k selects the k-th entry (0-based).
REQ-016 Decoding SHALL be the inverse of the encoder: for each token i in 0..tok_len-1, the bytes of entry tok[i], excluding the terminator, are written to consecutive output addresses starting at ao=0.
REQ-017 States: IDLE, TOK_RD, TOK_WAIT, SEEK_RD, SEEK_CHK, COPY_RD, COPY_CHK, DONE, ERR.
REQ-018 IDLE: if cs=1, latch tok_len, clear token index ti and ao counter; go to DONE if tok_len=0, else TOK_RD.
REQ-019 TOK_RD: drive ar=ti; next TOK_WAIT. TOK_WAIT: latch tok_data into remaining-terminator count npv, set av=0; next COPY_RD if npv=0, else SEEK_RD.
REQ-020 SEEK_RD presents av; SEEK_CHK examines val_vocab: if 0x00, decrement npv; av increments every SEEK_CHK; when npv reaches 0 go to COPY_RD, else SEEK_RD.
REQ-021 COPY_RD presents av; COPY_CHK: if val_vocab=0x00, increment ti and go to DONE when ti equals tok_len-1 else TOK_RD; otherwise w=1, w_data=val_vocab, ao=current write pointer for exactly that cycle, then pointer and av increment, next COPY_RD.
REQ-022 Every memory access SHALL use one outstanding read: address in *_RD state, data consumed in following *_CHK/*_WAIT state (2 cycles per vocab byte).
REQ-023 Vocab overrun: in SEEK_CHK or COPY_CHK with av=2^ADDR_WIDTH-1 and the byte non-terminating (copy) or npv not yet satisfied (seek) -> ERR; no wrap-around.
REQ-024 Output overflow: a write required when write pointer already wrapped past 2^ADDR_WIDTH-1 -> ERR, no write issued.
REQ-025 Empty entry (terminator at entry start) SHALL produce no writes and advance to next token.
REQ-026 DONE and ERR hold done=1 / err=1 until cs=0, then return to IDLE; done and err never both high.
REQ-027 cs deassertion during a run SHALL be ignored; the run completes.
REQ-028 w SHALL be 0 in every state other than a writing COPY_CHK cycle.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE and ar, av, ao, w_data, w, done, err, ti, npv to 0, including mid-run.
REQ-030 After rst_n rises, no activity until cs=1 is sampled in IDLE.

Verification
REQ-031 Vocab 61 00 62 63 00 64 00, tokens [1,0,2], tok_len=3 -> writes (0,62),(1,63),(2,61),(3,64), then done=1, err=0.
REQ-032 tok_len=0, cs=1 -> DONE on next cycle, no w pulse, done=1 until cs=0.
REQ-033 Vocab 00 41 00, tokens [0,1] -> single write (0,41), done=1.
REQ-034 Vocab 16 bytes with no 0x00, token [1] -> err=1 after SEEK_CHK at av=15, done=0, no writes.
REQ-035 rst_n pulsed low during COPY of scenario REQ-031 -> all outputs 0 asynchronously; rerun with cs=1 reproduces REQ-031 result exactly.
REQ-036 cs dropped to 0 mid-run of REQ-031 -> identical writes; done rises then falls the cycle after cs=0 is sampled in DONE.
